multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
Control unit for the multicycle RV32I core. A Moore main FSM sequences each instruction through Fetch, Decode, Execute, Memory and Writeback steps. It drives every datapath enable and mux select, including RegWrite, which feeds the register file's write-enable port (we3). Combinational ALU and immediate decoders complete the control word.

Parameters:
OPW, 7, opcode width (fixed by ISA; present for package reuse)
STW, 4, state register width

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high reset
op  in  7  instr[6:0] from instruction register
funct3  in  3  instr[14:12]
funct7b5  in  1  instr[30]
zero  in  1  ALU zero flag
pc_write  out  1  PC register enable = pc_update | (branch & zero)
adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut
mem_write  out  1  data memory write enable
ir_write  out  1  instruction/OldPC register enable
reg_write  out  1  register file write enable (to we3)
result_src  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
alu_src_a  out  2  00 = PC, 01 = OldPC, 10 = A register
alu_src_b  out  2  00 = B register, 01 = ImmExt, 10 = constant 4
alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
imm_src  out  2  00 = I-type, 01 = S-type, 10 = B-type, 11 = J-type
illegal_op  out  1  one-cycle pulse in Decode when the opcode is unsupported
state_dbg  out  4  current state encoding (debug/verification)

Behaviour:
- Single state register, updated on posedge clk. If reset = 1, next state = FETCH.
- While reset = 1: pc_write, ir_write, reg_write, mem_write and illegal_op are forced to 0. Selects show FETCH values. alu_control shows 000.
- First cycle after reset is released is FETCH.
- Outputs are a function of state only, plus op/funct for alu_control and imm_src. Any output not listed for a state is 0.
- FETCH: adr_src=0, ir_write=1, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10, pc_update=1. Next state: DECODE.
- DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (branch/jump target into ALUOut). Next state by op:
  - 0000011 (lw) or 0100011 (sw) -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - any other opcode -> FETCH, with illegal_op=1 for this cycle and no write enables.
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. Next: MEMREAD if lw, MEMWRITE if sw.
- MEMREAD: result_src=00, adr_src=1. Next: MEMWB.
- MEMWB: result_src=01, reg_write=1. Next: FETCH.
- MEMWRITE: result_src=00, adr_src=1, mem_write=1. Next: FETCH.
- EXECR: alu_src_a=10, alu_src_b=00, alu_op=10. Next: ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, alu_op=10. Next: ALUWB.
- ALUWB: result_src=00, reg_write=1. Next: FETCH.
- BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, branch=1. Next: FETCH.
- JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_update=1. Next: ALUWB (writes PC+4 to rd).
- Cycle counts (including FETCH): lw 5, sw 4, R-type 4, I-ALU 4, beq 3, jal 4, illegal 2.
- ALU decoder, by alu_op:
  - 00 -> add
  - 01 -> sub
  - 10 -> by funct3:
    - 000: sub if (op[5] & funct7b5), else add
    - 010 -> slt
    - 110 -> or
    - 111 -> and
    - any other funct3 -> add
- imm_src by op: lw/I-ALU 00, sw 01, beq 10, jal 11, others 00. Decoded in every state.
- Unused state encodings go to FETCH with all enables 0.
- reset asserted mid-instruction: the next cycle is FETCH and no write enable is asserted during the reset cycle, so a pending MEMWB/ALUWB write is dropped.

Decomposition:
- Shared package riscv_ctrl_pkg holds:
  - state encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10
  - opcode constants
  - alu_control codes
  - result_src, alu_src_a and alu_src_b select codes
- One sub-module, alu_decoder, with inputs alu_op, funct3, op5, funct7b5 and output alu_control. imm_src decode stays inline.

Test Plan:
- Reset held 3 cycles with op=0110011 -> state_dbg=0 and all enables 0; after release, cycle 1 shows ir_write=1, pc_write=1, alu_src_b=10, result_src=10.
- R-type sub (op=0110011, funct3=000, funct7b5=1) -> states 0,1,6,8; alu_control=001 in EXECR; reg_write=1 only in cycle 4.
- lw (op=0000011) then sw (op=0100011) -> lw states 0,1,2,3,4 with reg_write in cycle 5 and result_src=01; sw states 0,1,2,5 with mem_write=1 and adr_src=1 in cycle 4, reg_write never asserted; imm_src=00 for lw, 01 for sw.
- beq with zero=1, then with zero=0 -> in BEQ state, pc_write=1 and 0 respectively; alu_control=001 and imm_src=10.
- jal (op=1101111) -> states 0,1,10,8; pc_write=1 in JAL; reg_write=1 in ALUWB with result_src=00.
- Illegal op=1111111 -> states 0,1,0; illegal_op=1 for exactly the DECODE cycle. Separately, reset asserted during ALUWB -> reg_write=0 in that cycle and next state is FETCH.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multicycle RV32I control path: state encodings,
// opcodes, ALU codes, datapath select codes and the per-state control word.
package riscv_ctrl_pkg;

   localparam int OPCODE_W = 7;
   localparam int STATE_W  = 4;

   typedef enum logic [STATE_W-1:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECR    = 4'd6,
      EXECI    = 4'd7,
      ALUWB    = 4'd8,
      BEQ      = 4'd9,
      JAL      = 4'd10
   } state_t;

   localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
   localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
   localparam logic [OPCODE_W-1:0] OP_RTYPE  = 7'b0110011;
   localparam logic [OPCODE_W-1:0] OP_ITYPE  = 7'b0010011;
   localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
   localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } alu_op_t;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_REG   = 2'b10;

   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   typedef struct packed {
      logic       pc_update;
      logic       branch;
      logic       adr_src;
      logic       mem_write;
      logic       ir_write;
      logic       reg_write;
      logic [1:0] result_src;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      alu_op_t    alu_op;
   } ctrl_t;

   function automatic logic op_supported(input logic [OPCODE_W-1:0] op);
      return (op == OP_LOAD)  || (op == OP_STORE)  || (op == OP_RTYPE) ||
             (op == OP_ITYPE) || (op == OP_BRANCH) || (op == OP_JAL);
   endfunction

   // Moore control word for each state; unlisted fields stay 0.
   function automatic ctrl_t state_ctrl(input state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         FETCH: begin
            c.ir_write   = 1'b1;
            c.pc_update  = 1'b1;
            c.alu_src_a  = SRCA_PC;
            c.alu_src_b  = SRCB_FOUR;
            c.result_src = RES_ALURESULT;
            c.alu_op     = ALUOP_ADD;
         end
         DECODE: begin
            c.alu_src_a = SRCA_OLDPC;
            c.alu_src_b = SRCB_IMM;
            c.alu_op    = ALUOP_ADD;
         end
         MEMADR: begin
            c.alu_src_a = SRCA_REG;
            c.alu_src_b = SRCB_IMM;
            c.alu_op    = ALUOP_ADD;
         end
         MEMREAD: begin
            c.result_src = RES_ALUOUT;
            c.adr_src    = 1'b1;
         end
         MEMWB: begin
            c.result_src = RES_DATA;
            c.reg_write  = 1'b1;
         end
         MEMWRITE: begin
            c.result_src = RES_ALUOUT;
            c.adr_src    = 1'b1;
            c.mem_write  = 1'b1;
         end
         EXECR: begin
            c.alu_src_a = SRCA_REG;
            c.alu_src_b = SRCB_REG;
            c.alu_op    = ALUOP_FUNCT;
         end
         EXECI: begin
            c.alu_src_a = SRCA_REG;
            c.alu_src_b = SRCB_IMM;
            c.alu_op    = ALUOP_FUNCT;
         end
         ALUWB: begin
            c.result_src = RES_ALUOUT;
            c.reg_write  = 1'b1;
         end
         BEQ: begin
            c.alu_src_a  = SRCA_REG;
            c.alu_src_b  = SRCB_REG;
            c.alu_op     = ALUOP_SUB;
            c.result_src = RES_ALUOUT;
            c.branch     = 1'b1;
         end
         JAL: begin
            c.alu_src_a  = SRCA_OLDPC;
            c.alu_src_b  = SRCB_FOUR;
            c.alu_op     = ALUOP_ADD;
            c.result_src = RES_ALUOUT;
            c.pc_update  = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's ALU operation class plus funct fields to the ALU control code.
module alu_decoder
   import riscv_ctrl_pkg::*;
(
   input  alu_op_t    alu_op,
   input  logic [2:0] funct3,
   input  logic       op5,
   input  logic       funct7b5,
   output logic [2:0] alu_control
);

   always_comb begin
      alu_control = ALU_ADD;
      case (alu_op)
         ALUOP_ADD: alu_control = ALU_ADD;
         ALUOP_SUB: alu_control = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3)
               // op5 separates R-type sub from addi, whose imm bit 30 is data
               3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
               3'b010:  alu_control = ALU_SLT;
               3'b110:  alu_control = ALU_OR;
               3'b111:  alu_control = ALU_AND;
               default: alu_control = ALU_ADD;
            endcase
         end
         default: alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore main FSM for the multicycle RV32I core; state-only control fields are
// registered alongside the state, op-dependent decodes stay combinational.
module multicycle_control_unit
   import riscv_ctrl_pkg::*;
#(
   parameter int OPW = OPCODE_W,
   parameter int STW = STATE_W
)
(
   input  logic           clk,
   input  logic           reset,
   input  logic [OPW-1:0] op,
   input  logic [2:0]     funct3,
   input  logic           funct7b5,
   input  logic           zero,
   output logic           pc_write,
   output logic           adr_src,
   output logic           mem_write,
   output logic           ir_write,
   output logic           reg_write,
   output logic [1:0]     result_src,
   output logic [1:0]     alu_src_a,
   output logic [1:0]     alu_src_b,
   output logic [2:0]     alu_control,
   output logic [1:0]     imm_src,
   output logic           illegal_op,
   output logic [STW-1:0] state_dbg
);

   state_t state;
   state_t state_next;
   ctrl_t  ctrl_q;
   ctrl_t  ctrl_out;

   always_comb begin
      state_next = FETCH;
      case (state)
         FETCH: state_next = DECODE;
         DECODE: begin
            case (op)
               OP_LOAD, OP_STORE: state_next = MEMADR;
               OP_RTYPE:          state_next = EXECR;
               OP_ITYPE:          state_next = EXECI;
               OP_BRANCH:         state_next = BEQ;
               OP_JAL:            state_next = JAL;
               default:           state_next = FETCH;
            endcase
         end
         MEMADR:   state_next = (op == OP_STORE) ? MEMWRITE : MEMREAD;
         MEMREAD:  state_next = MEMWB;
         MEMWB:    state_next = FETCH;
         MEMWRITE: state_next = FETCH;
         EXECR:    state_next = ALUWB;
         EXECI:    state_next = ALUWB;
         ALUWB:    state_next = FETCH;
         BEQ:      state_next = FETCH;
         JAL:      state_next = ALUWB;
         default:  state_next = FETCH;
      endcase
   end

   // Control word is loaded for the state being entered so it lines up with it.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= FETCH;
         ctrl_q <= state_ctrl(FETCH);
      end else begin
         state  <= state_next;
         ctrl_q <= state_ctrl(state_next);
      end
   end

   // Reset is synchronous, so the cycle in which it is held must still be
   // masked: show FETCH selects and drop any pending write.
   always_comb begin
      ctrl_out = ctrl_q;
      if (reset) begin
         ctrl_out           = state_ctrl(FETCH);
         ctrl_out.pc_update = 1'b0;
         ctrl_out.branch    = 1'b0;
         ctrl_out.ir_write  = 1'b0;
         ctrl_out.reg_write = 1'b0;
         ctrl_out.mem_write = 1'b0;
      end
   end

   always_comb begin
      imm_src = IMM_I;
      case (op)
         OP_STORE:  imm_src = IMM_S;
         OP_BRANCH: imm_src = IMM_B;
         OP_JAL:    imm_src = IMM_J;
         default:   imm_src = IMM_I;
      endcase
   end

   alu_decoder u_alu_decoder (
      .alu_op      (ctrl_out.alu_op),
      .funct3      (funct3),
      .op5         (op[5]),
      .funct7b5    (funct7b5),
      .alu_control (alu_control)
   );

   assign pc_write   = ctrl_out.pc_update | (ctrl_out.branch & zero);
   assign adr_src    = ctrl_out.adr_src;
   assign mem_write  = ctrl_out.mem_write;
   assign ir_write   = ctrl_out.ir_write;
   assign reg_write  = ctrl_out.reg_write;
   assign result_src = ctrl_out.result_src;
   assign alu_src_a  = ctrl_out.alu_src_a;
   assign alu_src_b  = ctrl_out.alu_src_b;
   assign illegal_op = ~reset & (state == DECODE) & ~op_supported(op);
   assign state_dbg  = STW'(state);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: instruction-path model
// compared every cycle, plus hand-computed literal checks per instruction.
module tb_multicycle_control_unit;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       zero;
   logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_op;
   logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
   logic [2:0] alu_control;
   logic [3:0] state_dbg;

   int n_checks = 0;
   int n_pass   = 0;

   multicycle_control_unit #(.OPW(7), .STW(4)) dut (
      .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
      .zero(zero), .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
      .ir_write(ir_write), .reg_write(reg_write), .result_src(result_src),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
      .imm_src(imm_src), .illegal_op(illegal_op), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // ---------------- model: instruction paths and per-state control tables
   int path[5];
   int plen = 1;
   int pos  = 0;
   int exp_state = 0;
   bit model_valid = 1'b0;

   bit [10:0] t_pc_upd = 11'b100_0000_0001;
   bit [10:0] t_branch = 11'b010_0000_0000;
   bit [10:0] t_adr    = 11'b000_0010_1000;
   bit [10:0] t_mw     = 11'b000_0010_0000;
   bit [10:0] t_irw    = 11'b000_0000_0001;
   bit [10:0] t_rw     = 11'b001_0001_0000;
   int t_res [11] = '{2, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
   int t_srca[11] = '{0, 1, 2, 0, 0, 0, 2, 2, 0, 2, 1};
   int t_srcb[11] = '{2, 1, 1, 0, 0, 0, 0, 1, 0, 0, 2};

   task automatic set_path(input logic [6:0] o);
      path[0] = 0; path[1] = 1;
      case (o)
         7'b0000011: begin path[2] = 2;  path[3] = 3; path[4] = 4; plen = 5; end
         7'b0100011: begin path[2] = 2;  path[3] = 5; plen = 4; end
         7'b0110011: begin path[2] = 6;  path[3] = 8; plen = 4; end
         7'b0010011: begin path[2] = 7;  path[3] = 8; plen = 4; end
         7'b1100011: begin path[2] = 9;  plen = 3; end
         7'b1101111: begin path[2] = 10; path[3] = 8; plen = 4; end
         default:    plen = 2;
      endcase
   endtask

   function automatic logic [20:0] model_out(input int s, input logic rst, input logic [6:0] o,
                                             input logic [2:0] f3, input logic f7, input logic z);
      logic [1:0] imm;
      logic [2:0] alu;
      logic       legal, pcw;
      logic [3:0] sv;
      sv    = s[3:0];
      legal = (o == 7'b0000011) || (o == 7'b0100011) || (o == 7'b0110011) ||
              (o == 7'b0010011) || (o == 7'b1100011) || (o == 7'b1101111);
      case (o)
         7'b0100011: imm = 2'd1;
         7'b1100011: imm = 2'd2;
         7'b1101111: imm = 2'd3;
         default:    imm = 2'd0;
      endcase
      if (rst) return {sv, 5'b0, 2'd2, 2'd0, 2'd2, 3'd0, imm, 1'b0};
      alu = 3'd0;
      if (s == 9) alu = 3'd1;
      else if (s == 6 || s == 7) begin
         case (f3)
            3'b000:  alu = (o[5] && f7) ? 3'd1 : 3'd0;
            3'b010:  alu = 3'd5;
            3'b110:  alu = 3'd3;
            3'b111:  alu = 3'd2;
            default: alu = 3'd0;
         endcase
      end
      pcw = t_pc_upd[s] | (t_branch[s] & z);
      return {sv, pcw, t_adr[s], t_mw[s], t_irw[s], t_rw[s],
              2'(t_res[s]), 2'(t_srca[s]), 2'(t_srcb[s]), alu, imm,
              (s == 1) && !legal};
   endfunction

   initial begin
      forever begin
         @(posedge clk);
         if (reset) begin pos = 0; plen = 1; path[0] = 0; end
         else if (pos == 0) begin set_path(op); pos = 1; end
         else if (pos + 1 < plen) pos = pos + 1;
         else pos = 0;
         exp_state   = path[pos];
         model_valid = 1'b1;
      end
   end

   initial begin
      logic [20:0] act, exp;
      forever begin
         @(negedge clk);
         if (model_valid) begin
            exp = model_out(exp_state, reset, op, funct3, funct7b5, zero);
            act = {state_dbg, pc_write, adr_src, mem_write, ir_write, reg_write,
                   result_src, alu_src_a, alu_src_b, alu_control, imm_src, illegal_op};
            chk($sformatf("cycle_state%0d", exp_state), 32'(act), 32'(exp));
         end
      end
   end

   // ---------------- directed stimulus with per-cycle logs
   logic [3:0] st_l[8];
   logic       pcw_l[8], rw_l[8], mw_l[8], adr_l[8], irw_l[8], ill_l[8];
   logic [1:0] rs_l[8], srcb_l[8], imm_l[8];
   logic [2:0] alu_l[8];

   task automatic run(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                      input logic z, input int n);
      op = o; funct3 = f3; funct7b5 = f7; zero = z;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         st_l[k] = state_dbg;  pcw_l[k] = pc_write; rw_l[k] = reg_write;
         mw_l[k] = mem_write;  adr_l[k] = adr_src;  irw_l[k] = ir_write;
         ill_l[k] = illegal_op; rs_l[k] = result_src; srcb_l[k] = alu_src_b;
         imm_l[k] = imm_src;   alu_l[k] = alu_control;
         @(posedge clk); #1;
      end
   endtask

   initial begin
      reset = 1'b1; op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_state", 32'(state_dbg), 32'h0);
      chk("reset_enables", 32'({pc_write, ir_write, reg_write, mem_write, illegal_op}), 32'h0);
      chk("reset_srcb", 32'(alu_src_b), 32'h2);
      @(posedge clk); #1 reset = 1'b0;

      run(7'b0110011, 3'b000, 1'b1, 1'b0, 4);
      chk("fetch_after_reset", 32'({irw_l[0], pcw_l[0], srcb_l[0], rs_l[0]}), 32'b1_1_10_10);
      chk("r_states", 32'({st_l[0], st_l[1], st_l[2], st_l[3]}), 32'h0168);
      chk("r_sub_alu", 32'(alu_l[2]), 32'h1);
      chk("r_rw", 32'({rw_l[0], rw_l[1], rw_l[2], rw_l[3]}), 32'b0001);

      run(7'b0000011, 3'b010, 1'b0, 1'b0, 5);
      chk("lw_states", 32'({st_l[0], st_l[1], st_l[2], st_l[3], st_l[4]}), 32'h01234);
      chk("lw_wb", 32'({rw_l[4], rs_l[4], imm_l[0]}), 32'b1_01_00);

      run(7'b0100011, 3'b010, 1'b0, 1'b0, 4);
      chk("sw_states", 32'({st_l[0], st_l[1], st_l[2], st_l[3]}), 32'h0125);
      chk("sw_write", 32'({mw_l[3], adr_l[3], imm_l[0]}), 32'b1_1_01);
      chk("sw_no_rw", 32'({rw_l[0], rw_l[1], rw_l[2], rw_l[3]}), 32'h0);

      run(7'b1100011, 3'b000, 1'b0, 1'b1, 3);
      chk("beq_taken", 32'({st_l[2], pcw_l[2], alu_l[2], imm_l[2]}), 32'b1001_1_001_10);
      run(7'b1100011, 3'b000, 1'b0, 1'b0, 3);
      chk("beq_not_taken_pcw", 32'(pcw_l[2]), 32'h0);

      run(7'b1111111, 3'b000, 1'b0, 1'b0, 2);
      chk("illegal_states", 32'({st_l[0], st_l[1]}), 32'h01);
      chk("illegal_pulse", 32'({ill_l[0], ill_l[1]}), 32'b01);

      run(7'b0010011, 3'b110, 1'b0, 1'b0, 4);
      chk("fetch_after_illegal", 32'(st_l[0]), 32'h0);
      chk("ori_alu", 32'({st_l[2], alu_l[2]}), 32'b0111_011);
      run(7'b0010011, 3'b000, 1'b1, 1'b0, 4);
      chk("addi_bit30_is_add", 32'(alu_l[2]), 32'h0);
      run(7'b0110011, 3'b010, 1'b0, 1'b0, 4);
      chk("slt_alu", 32'(alu_l[2]), 32'h5);
      run(7'b0110011, 3'b001, 1'b0, 1'b0, 4);
      chk("other_funct3_add", 32'(alu_l[2]), 32'h0);

      op = 7'b0110011; funct3 = 3'b111; funct7b5 = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      reset = 1'b1;
      @(negedge clk);
      chk("rst_in_aluwb_state", 32'(state_dbg), 32'h8);
      chk("rst_in_aluwb_rw", 32'(reg_write), 32'h0);
      @(posedge clk); #1 reset = 1'b0;

      run(7'b1101111, 3'b000, 1'b0, 1'b0, 4);
      chk("jal_states", 32'({st_l[0], st_l[1], st_l[2], st_l[3]}), 32'h01A8);
      chk("jal_ctrl", 32'({pcw_l[2], rw_l[3], rs_l[3], imm_l[0]}), 32'b1_1_00_11);

      @(negedge clk);
      chk("end_fetch", 32'(state_dbg), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
